// File: rtl/perip_responder_if.sv
// CPU data-side bus between the core (master) and the peripheral responder (slave).
// Latency: none (wires only); read data is returned by the slave one cycle after the address.
// Backpressure: none; the bus carries exactly one access per cycle.
interface perip_responder_if;
   logic [31:0] perip_addr;
   logic        perip_wen;
   logic [1:0]  perip_mask;
   logic [31:0] perip_wdata;
   logic [31:0] perip_rdata;

   modport master (
      output perip_addr,
      output perip_wen,
      output perip_mask,
      output perip_wdata,
      input  perip_rdata
   );

   modport slave (
      input  perip_addr,
      input  perip_wen,
      input  perip_mask,
      input  perip_wdata,
      output perip_rdata
   );
endinterface

// File: rtl/perip_responder.sv
// Data RAM plus MMIO page (switches, LEDs, seven-segment, cycle counter, optional UART TX).
// Latency: reads return the aligned word exactly 1 cycle after the address; writes land on that edge.
// Backpressure: none; UART_DATA writes arriving while the transmitter is busy are dropped.
// Optional feature: define PERIP_UART_EN to build the UART transmitter; otherwise uart_tx_o is tied high.
module perip_responder #(
   parameter logic [31:0] DRAM_BASE    = 32'h8010_0000,
   parameter int unsigned DRAM_WORDS   = 65536,
   parameter logic [31:0] PERIP_BASE   = 32'h8020_0000,
   parameter int unsigned CLKS_PER_BIT = 434
) (
   input  logic                    clk,
   input  logic                    rst,
   perip_responder_if.slave        bus,
   input  logic [15:0]             sw_i,
   output logic [15:0]             led_o,
   output logic [31:0]             seg_data_o,
   output logic                    uart_tx_o
);
   localparam int unsigned IDX_W      = $clog2(DRAM_WORDS);
   localparam logic [32:0] DRAM_BYTES = 33'(DRAM_WORDS) << 2;

   // MMIO word offsets (byte offset >> 2)
   localparam logic [9:0] OFF_SW    = 10'h000;
   localparam logic [9:0] OFF_LED   = 10'h008;
   localparam logic [9:0] OFF_SEG   = 10'h010;
   localparam logic [9:0] OFF_CNT   = 10'h014;
   localparam logic [9:0] OFF_UDATA = 10'h018;
   localparam logic [9:0] OFF_USTAT = 10'h019;

   // ---------------- decode ----------------
   logic [31:0]      ram_off;
   logic             ram_hit;
   logic             mmio_hit;
   logic [IDX_W-1:0] ram_idx;
   logic [9:0]       mmio_word;

   assign ram_off   = bus.perip_addr - DRAM_BASE;
   assign ram_hit   = ({1'b0, ram_off} < DRAM_BYTES);
   assign ram_idx   = ram_off[IDX_W+1:2];
   assign mmio_hit  = !ram_hit && (bus.perip_addr[31:12] == PERIP_BASE[31:12]);
   assign mmio_word = bus.perip_addr[11:2];

   logic mmio_wr;
   assign mmio_wr = bus.perip_wen && mmio_hit;

   // ---------------- RAM ----------------
   logic [3:0][7:0] mem_q [DRAM_WORDS];
   logic [3:0][7:0] ram_rd_q;
   logic [3:0]      wr_be;
   logic [3:0][7:0] wr_lane;

   // Byte enables and lane-replicated write data from size and low address bits
   always_comb begin
      wr_be   = 4'b0000;
      wr_lane = bus.perip_wdata;
      case (bus.perip_mask)
         2'b00: begin
            wr_be   = 4'b0001 << bus.perip_addr[1:0];
            wr_lane = {4{bus.perip_wdata[7:0]}};
         end
         2'b01: begin
            // misaligned halfword stores are dropped
            if (!bus.perip_addr[0]) begin
               wr_be = bus.perip_addr[1] ? 4'b1100 : 4'b0011;
            end
            wr_lane = {2{bus.perip_wdata[15:0]}};
         end
         default: wr_be = 4'b1111;
      endcase
   end

   // Read-first RAM port: same-cycle read of a written word returns the old contents
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (bus.perip_wen && ram_hit && wr_be[i]) begin
            mem_q[ram_idx][i] <= wr_lane[i];
         end
      end
      ram_rd_q <= mem_q[ram_idx];
   end

   // ---------------- MMIO registers ----------------
   logic [15:0] led_q;
   logic [31:0] seg_q;
   logic [31:0] cnt_q;
   logic        uart_busy;

   // LED and seven-segment registers take the full write data regardless of size
   always_ff @(posedge clk) begin
      if (rst) begin
         led_q <= '0;
         seg_q <= '0;
      end else if (mmio_wr) begin
         if (mmio_word == OFF_LED) led_q <= bus.perip_wdata[15:0];
         if (mmio_word == OFF_SEG) seg_q <= bus.perip_wdata;
      end
   end

   // Free-running cycle counter; a CPU write wins over the increment
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (mmio_wr && (mmio_word == OFF_CNT)) begin
         cnt_q <= bus.perip_wdata;
      end else begin
         cnt_q <= cnt_q + 32'd1;
      end
   end

   assign led_o      = led_q;
   assign seg_data_o = seg_q;

`ifdef PERIP_UART_EN
   // ---------------- UART transmitter ----------------
   localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_e;

   uart_state_e       state_q, state_d;
   logic [BAUD_W-1:0] baud_q;
   logic [2:0]        bit_q;
   logic [7:0]        data_q;
   logic              uart_wr;
   logic              baud_last;

   assign uart_wr   = mmio_wr && (mmio_word == OFF_UDATA);
   assign baud_last = (baud_q == BAUD_LAST);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state_q <= U_IDLE;
      else     state_q <= state_d;
   end

   // FSM next state: one start bit, eight data bits, one stop bit
   always_comb begin
      state_d = state_q;
      case (state_q)
         U_IDLE:  if (uart_wr)                    state_d = U_START;
         U_START: if (baud_last)                  state_d = U_DATA;
         U_DATA:  if (baud_last && bit_q == 3'd7) state_d = U_STOP;
         U_STOP:  if (baud_last)                  state_d = U_IDLE;
         default:                                 state_d = U_IDLE;
      endcase
   end

   // FSM outputs: line level and busy flag
   always_comb begin
      uart_busy = (state_q != U_IDLE);
      uart_tx_o = 1'b1;
      case (state_q)
         U_START: uart_tx_o = 1'b0;
         U_DATA:  uart_tx_o = data_q[bit_q];
         default: uart_tx_o = 1'b1;
      endcase
   end

   // Baud/bit counters and the byte latched when a frame is accepted
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_q <= '0;
         bit_q  <= '0;
         data_q <= '0;
      end else if (state_q == U_IDLE) begin
         baud_q <= '0;
         bit_q  <= '0;
         if (uart_wr) data_q <= bus.perip_wdata[7:0];
      end else begin
         baud_q <= baud_last ? '0 : baud_q + 1'b1;
         if (state_q == U_DATA && baud_last) bit_q <= bit_q + 3'd1;
      end
   end
`else
   assign uart_busy = 1'b0;
   assign uart_tx_o = 1'b1;
`endif

   // ---------------- read path ----------------
   logic [31:0] mmio_rd_d;
   logic [31:0] mmio_rd_q;
   logic        rd_ram_q;

   // MMIO read mux; unmapped and write-only offsets read zero
   always_comb begin
      mmio_rd_d = '0;
      if (mmio_hit) begin
         case (mmio_word)
            OFF_SW:    mmio_rd_d = {16'h0000, sw_i};
            OFF_LED:   mmio_rd_d = {16'h0000, led_q};
            OFF_SEG:   mmio_rd_d = seg_q;
            OFF_CNT:   mmio_rd_d = cnt_q;
            OFF_USTAT: mmio_rd_d = {31'd0, uart_busy};
            default:   mmio_rd_d = '0;
         endcase
      end
   end

   // Register the MMIO read value and which source answers next cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         mmio_rd_q <= '0;
         rd_ram_q  <= 1'b0;
      end else begin
         mmio_rd_q <= mmio_rd_d;
         rd_ram_q  <= ram_hit;
      end
   end

   assign bus.perip_rdata = rd_ram_q ? ram_rd_q : mmio_rd_q;

endmodule

// File: tb/tb_perip_responder.sv
// Randomized bench for perip_responder against a word-level reference model.
// Latency: checks read data, LEDs, segments and UART line one cycle after each access.
// Backpressure: none; UART tests exercise dropped writes while busy.
module tb_perip_responder;
   localparam logic [31:0] DRAM_BASE  = 32'h8010_0000;
   localparam int          DRAM_WORDS = 256;
   localparam logic [31:0] PERIP_BASE = 32'h8020_0000;
   localparam int          CPB        = 4;
   localparam int          FRAME      = 10 * CPB;

   localparam logic [31:0] A_SW    = 32'h8020_0000;
   localparam logic [31:0] A_LED   = 32'h8020_0020;
   localparam logic [31:0] A_SEG   = 32'h8020_0040;
   localparam logic [31:0] A_CNT   = 32'h8020_0050;
   localparam logic [31:0] A_UDATA = 32'h8020_0060;
   localparam logic [31:0] A_USTAT = 32'h8020_0064;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] sw;
   logic [15:0] led;
   logic [31:0] seg;
   logic        tx;

   perip_responder_if bus ();

   perip_responder #(
      .DRAM_BASE    (DRAM_BASE),
      .DRAM_WORDS   (DRAM_WORDS),
      .PERIP_BASE   (PERIP_BASE),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .sw_i       (sw),
      .led_o      (led),
      .seg_data_o (seg),
      .uart_tx_o  (tx)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   // reference model state
   logic [31:0] ram_m [DRAM_WORDS];
   bit          ram_v [DRAM_WORDS];
   logic [15:0] led_m;
   logic [31:0] seg_m;
   logic [31:0] cnt_m;
   int          uart_k;   // cycles since frame acceptance; >= FRAME means idle
   logic [7:0]  uart_b;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic model_tx();
      int b;
      if (uart_k >= FRAME) return 1'b1;
      b = uart_k / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      return uart_b[b-1];
   endfunction

   // One bus access: model predicts, clock edge, then compare outputs
   task automatic cycle(input logic [31:0] a, input logic we, input logic [1:0] m,
                        input logic [31:0] wd);
      logic [31:0] off;
      logic [31:0] exp_rd;
      logic [31:0] w;
      logic [31:0] cnt_n;
      bit          rd_ok;
      bit          mmio;
      int          idx;
      bus.perip_addr  = a;
      bus.perip_wen   = we;
      bus.perip_mask  = m;
      bus.perip_wdata = wd;
      off    = a - DRAM_BASE;
      rd_ok  = 1'b1;
      exp_rd = 32'h0;
      mmio   = 1'b0;
      idx    = 0;
      if (off < 32'(DRAM_WORDS * 4)) begin
         idx    = int'(off >> 2);
         exp_rd = ram_m[idx];
         rd_ok  = ram_v[idx];
      end else if (a[31:12] == PERIP_BASE[31:12]) begin
         mmio = 1'b1;
         case ({a[11:2], 2'b00})
            12'h000: exp_rd = {16'h0, sw};
            12'h020: exp_rd = {16'h0, led_m};
            12'h040: exp_rd = seg_m;
            12'h050: exp_rd = cnt_m;
`ifdef PERIP_UART_EN
            12'h064: exp_rd = (uart_k < FRAME) ? 32'd1 : 32'd0;
`endif
            default: exp_rd = 32'h0;
         endcase
      end
      // state updates
      cnt_n = cnt_m + 32'd1;
      if (we && !mmio && off < 32'(DRAM_WORDS * 4)) begin
         w = ram_m[idx];
         case (m)
            2'b00: w[8*a[1:0] +: 8] = wd[7:0];
            2'b01: if (!a[0]) w[16*a[1] +: 16] = wd[15:0];
            default: w = wd;
         endcase
         ram_m[idx] = w;
         if (m[1]) ram_v[idx] = 1'b1;
      end
      if (uart_k < FRAME) begin
         uart_k++;
      end else if (we && mmio && {a[11:2], 2'b00} == 12'h060) begin
`ifdef PERIP_UART_EN
         uart_k = 0;
         uart_b = wd[7:0];
`endif
      end
      if (we && mmio) begin
         case ({a[11:2], 2'b00})
            12'h020: led_m = wd[15:0];
            12'h040: seg_m = wd;
            12'h050: cnt_n = wd;
            default: ;
         endcase
      end
      cnt_m = cnt_n;
      @(posedge clk);
      #1;
      if (rd_ok) chk("rdata", bus.perip_rdata, exp_rd);
      chk("led", {16'h0, led}, {16'h0, led_m});
      chk("seg", seg, seg_m);
      chk("uart_tx", {31'h0, tx}, {31'h0, model_tx()});
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.perip_wen = 1'b0;
      @(posedge clk);
      #1;
      led_m  = '0;
      seg_m  = '0;
      cnt_m  = '0;
      uart_k = FRAME;
      chk("rst_rdata", bus.perip_rdata, 32'h0);
      chk("rst_led", {16'h0, led}, 32'h0);
      chk("rst_seg", seg, 32'h0);
      chk("rst_tx", {31'h0, tx}, 32'h1);
      rst = 1'b0;
   endtask

   logic [11:0] offs [6] = '{12'h000, 12'h020, 12'h040, 12'h050, 12'h060, 12'h064};

   initial begin
      logic [31:0] a;
      rst             = 1'b1;
      sw              = 16'h0000;
      bus.perip_addr  = '0;
      bus.perip_wen   = 1'b0;
      bus.perip_mask  = 2'b10;
      bus.perip_wdata = '0;
      for (int i = 0; i < DRAM_WORDS; i++) ram_v[i] = 1'b0;
      @(posedge clk);
      #1;
      do_reset();

      // fill RAM so every later read has a known value
      for (int i = 0; i < DRAM_WORDS; i++)
         cycle(DRAM_BASE + 32'(i * 4), 1'b1, 2'b10, $urandom);

      // word write / read
      cycle(32'h8010_0010, 1'b1, 2'b10, 32'hDEAD_BEEF);
      cycle(32'h8010_0010, 1'b0, 2'b10, 32'h0);
      chk("tp1_word", bus.perip_rdata, 32'hDEAD_BEEF);
      // sub-word writes
      cycle(32'h8010_0011, 1'b1, 2'b00, 32'h0000_00AA);
      cycle(32'h8010_0010, 1'b0, 2'b10, 32'h0);
      chk("tp2_byte", bus.perip_rdata, 32'hDEAD_AAEF);
      cycle(32'h8010_0012, 1'b1, 2'b01, 32'h0000_1234);
      cycle(32'h8010_0010, 1'b0, 2'b10, 32'h0);
      chk("tp2_half", bus.perip_rdata, 32'h1234_AAEF);
      cycle(32'h8010_0013, 1'b1, 2'b01, 32'h0000_FFFF);
      cycle(32'h8010_0010, 1'b0, 2'b10, 32'h0);
      chk("tp2_half_misal", bus.perip_rdata, 32'h1234_AAEF);
      // read-first on same-word write
      cycle(32'h8010_0010, 1'b1, 2'b10, 32'h1111_2222);
      chk("read_first_old", bus.perip_rdata, 32'h1234_AAEF);
      cycle(32'h8010_0010, 1'b0, 2'b10, 32'h0);
      chk("read_first_new", bus.perip_rdata, 32'h1111_2222);
      // just past the RAM end must not alias word 0
      cycle(DRAM_BASE + 32'(DRAM_WORDS * 4), 1'b1, 2'b10, 32'h0BAD_0BAD);
      cycle(DRAM_BASE, 1'b0, 2'b10, 32'h0);

      // MMIO
      sw = 16'h00F0;
      cycle(A_SW, 1'b0, 2'b10, 32'h0);
      chk("tp3_sw", bus.perip_rdata, 32'h0000_00F0);
      cycle(A_LED, 1'b1, 2'b00, 32'h0001_5A5A);
      chk("tp3_led", {16'h0, led}, 32'h0000_5A5A);
      cycle(A_SEG, 1'b1, 2'b10, 32'hCAFE_0000);
      chk("tp3_seg", seg, 32'hCAFE_0000);
      cycle(32'h8020_0F00, 1'b0, 2'b10, 32'h0);
      chk("tp3_unmapped", bus.perip_rdata, 32'h0);
      cycle(A_SW, 1'b1, 2'b10, 32'hFFFF_FFFF);
      cycle(A_SW, 1'b0, 2'b10, 32'h0);
      chk("sw_ro", bus.perip_rdata, 32'h0000_00F0);

      // counter wrap
      cycle(A_CNT, 1'b1, 2'b10, 32'hFFFF_FFFE);
      cycle(A_CNT, 1'b0, 2'b10, 32'h0);
      cycle(A_CNT, 1'b0, 2'b10, 32'h0);
      chk("tp4_cnt_max", bus.perip_rdata, 32'hFFFF_FFFF);
      cycle(A_CNT, 1'b0, 2'b10, 32'h0);
      chk("tp4_cnt_wrap", bus.perip_rdata, 32'h0000_0000);

      // UART frame
      cycle(A_UDATA, 1'b1, 2'b10, 32'h0000_0055);
`ifdef PERIP_UART_EN
      chk("tp5_start", {31'h0, tx}, 32'h0);
      for (int i = 1; i <= FRAME; i++) begin
         if (i == 20) begin
            cycle(A_UDATA, 1'b1, 2'b10, 32'h0000_00FF);
         end else begin
            cycle(A_USTAT, 1'b0, 2'b10, 32'h0);
            chk("tp5_busy", bus.perip_rdata, 32'h1);
         end
         chk("tp5_tx", {31'h0, tx}, (i < FRAME) ? 32'((i / CPB) % 2) : 32'h1);
      end
      cycle(A_USTAT, 1'b0, 2'b10, 32'h0);
      chk("tp5_idle", bus.perip_rdata, 32'h0);
`else
      cycle(A_USTAT, 1'b0, 2'b10, 32'h0);
      chk("stat_off", bus.perip_rdata, 32'h0);
      chk("tx_off", {31'h0, tx}, 32'h1);
`endif

      // reset mid-frame
      cycle(A_UDATA, 1'b1, 2'b10, 32'h0000_0055);
      for (int i = 1; i < 10; i++) cycle(A_LED, 1'b0, 2'b10, 32'h0);
      do_reset();
      cycle(A_USTAT, 1'b0, 2'b10, 32'h0);
      chk("tp6_stat", bus.perip_rdata, 32'h0);
      cycle(A_CNT, 1'b0, 2'b10, 32'h0);
      chk("tp6_cnt", bus.perip_rdata, 32'h1);
      cycle(A_UDATA, 1'b1, 2'b10, 32'h0000_00A3);
`ifdef PERIP_UART_EN
      chk("tp6_new_start", {31'h0, tx}, 32'h0);
`endif
      for (int i = 0; i < FRAME + 2; i++) cycle(A_USTAT, 1'b0, 2'b10, 32'h0);

      // randomized traffic
      for (int n = 0; n < 800; n++) begin
         if ((n % 97) == 0) sw = 16'($urandom);
         case ($urandom_range(0, 9))
            0, 1, 2, 3:
               a = DRAM_BASE + ($urandom_range(0, DRAM_WORDS - 1) << 2) + $urandom_range(0, 3);
            4:
               a = DRAM_BASE + ($urandom_range(0, 3) << 2) + $urandom_range(0, 3);
            5, 6:
               a = PERIP_BASE + 32'(offs[$urandom_range(0, 5)]) + $urandom_range(0, 3);
            7:
               a = PERIP_BASE + ($urandom & 32'h0000_0FFF);
            8:
               a = DRAM_BASE + 32'(DRAM_WORDS * 4) + ($urandom & 32'h0000_00FF);
            default:
               a = $urandom;
         endcase
         cycle(a, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/perip_responder.md
Name: perip_responder

Overview:
- Slave/responder end of the CPU data-side bus (perip_addr / perip_wen / perip_mask / perip_wdata / perip_rdata).
- Holds the data RAM and a small MMIO block: switch input, LED register, seven-segment register, cycle counter and UART transmitter.
- Answers every CPU data access with a registered read, one cycle after the address is presented.
- Sits between the CPU top and the board pins in FPGA builds; the simulation bench instantiates it in place of the behavioural data memory.

Parameters:
- DRAM_BASE, 32'h8010_0000, byte base address of data RAM.
- DRAM_WORDS, 65536, RAM depth in 32-bit words (power of 2).
- PERIP_BASE, 32'h8020_0000, base of the MMIO page (4 KB).
- CLKS_PER_BIT, 434, UART bit period in clk cycles (>=2).

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- perip_addr, in, 32, byte address.
- perip_wen, in, 1, write strobe, one access per cycle.
- perip_mask, in, 2, access size: 00 byte, 01 half, 10/11 word.
- perip_wdata, in, 32, write data, LSB-aligned (byte in [7:0], half in [15:0]).
- perip_rdata, out, 32, registered read data.
- sw, in, 16, board switches.
- led, out, 16, LED register.
- seg_data, out, 32, seven-segment value register.
- uart_tx, out, 1, serial TX line, idle high.

Behaviour:
- Decode:
  - RAM hit when addr - DRAM_BASE < DRAM_WORDS*4; word index = offset[..:2].
  - MMIO hit when addr[31:12] == PERIP_BASE[31:12]. Offsets:
    - 0x000 SW (RO, zero-extended)
    - 0x020 LED (RW, [15:0])
    - 0x040 SEG (RW)
    - 0x050 CNT (RW)
    - 0x060 UART_DATA (WO)
    - 0x064 UART_STAT (RO, bit0 = busy)
  - Anything else is unmapped.
- Reads:
  - Every cycle, perip_rdata <= word at aligned address (addr[1:0] ignored); latency exactly 1 cycle, no handshake.
  - Full aligned word is returned; the CPU performs lane extraction and sign extension.
  - Unmapped or write-only offsets read 0.
- RAM writes:
  - Applied on the clk edge when perip_wen=1.
  - Byte: lane addr[1:0] <= wdata[7:0].
  - Half: lanes {addr[1],0..1} <= wdata[15:0]; ignored entirely if addr[0]=1.
  - Word: all lanes <= wdata; addr[1:0] is ignored.
  - Read-first: a read and write to the same word in the same cycle returns the old value; the following cycle returns the new value.
- MMIO writes:
  - Use wdata regardless of mask.
  - Writes to SW, UART_STAT and unmapped addresses are ignored.
- CNT:
  - Increments by 1 every cycle and wraps at 0xFFFF_FFFF -> 0.
  - A write loads wdata and takes priority over the increment that cycle.
- UART FSM, states IDLE, START, DATA, STOP:
  - IDLE: uart_tx=1, busy=0. A write to UART_DATA latches wdata[7:0] and moves to START on the same edge.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each; a bit counter selects the bit.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - busy=1 in all non-IDLE states. Writes to UART_DATA while busy are dropped (no queue).
  - Frame length = 10*CLKS_PER_BIT cycles from the accepting edge to IDLE.
- Reset values: perip_rdata=0, led=0, seg_data=0, CNT=0, UART state IDLE, uart_tx=1, bit/baud counters 0. RAM contents are not reset.
- Reset mid-frame: on the next edge uart_tx=1 and state=IDLE; the partial frame is abandoned.

Optional Feature:
- Macro PERIP_UART_EN.
- Defined: UART FSM present as described above.
- Undefined:
  - No UART logic is synthesised; uart_tx is tied to 1.
  - UART_STAT reads 0 and UART_DATA writes are ignored.
  - All other behaviour is unchanged.

Test Plan:
1. Word write 0xDEADBEEF to 0x8010_0010, then read the same address -> perip_rdata=0xDEADBEEF one cycle after the read address is presented.
2. Sub-word writes:
   - After scenario 1, byte write 0xAA at 0x8010_0011 -> word reads 0xDEADAAEF.
   - Half write 0x1234 at 0x8010_0012 -> word reads 0x1234AAEF.
   - Half write at 0x8010_0013 -> word unchanged.
3. MMIO:
   - sw=0x00F0; read 0x8020_0000 -> 0x0000_00F0.
   - Write 0x1_5A5A to LED -> led=0x5A5A.
   - Write 0xCAFE_0000 to SEG -> seg_data=0xCAFE_0000.
   - Read 0x8020_0F00 -> 0.
4. Counter: write 0xFFFF_FFFE to CNT, then read it on the 2nd and 3rd cycles after the write -> 0xFFFF_FFFF, then 0x0000_0000 (wrap).
5. UART (PERIP_UART_EN, CLKS_PER_BIT=4):
   - Write 0x55 -> uart_tx sequence 0,1,0,1,0,1,0,1,0,1 with each level held 4 cycles; STAT=1 during the 40 cycles, then 0.
   - A second write issued mid-frame is dropped.
6. Reset mid-frame:
   - Assert rst at cycle 10 of a frame -> uart_tx=1, STAT=0, led=0, CNT=0, perip_rdata=0 after the edge.
   - The next UART write starts a clean frame.
